bsg_manycore_edge_arbiter: RTL and testbench

Shares one mesh edge injection port among `num_req_p` host-side requesters, such as an array side's `ver_data_i[S][c]` link. Arbitration is round-robin and is gated by an outstanding-request credit counter. Return packets replenish credits, and a drain request lets the host quiesce the port before reconfiguration or reset. The block sits between the I/O complex and one edge link of the tile array.

---
 rtl/bsg_vscale_pkg.sv | 15 +
 rtl/bsg_manycore_edge_arbiter_pick.sv | 29 ++
 rtl/bsg_manycore_edge_arbiter.sv | 113 +++++++++++
 tb/tb_bsg_manycore_edge_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_vscale_pkg.sv
// Array-wide shared types and helpers for the manycore edge logic.
package bsg_vscale_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } bsg_edge_arb_state_e;

    // Width that still yields at least one bit for degenerate sizes.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_manycore_edge_arbiter_pick.sv
// Combinational round-robin pick: first valid requester after last_i, wrapping.
module bsg_round_robin_pick #(
    parameter int unsigned num_req_p  = 4,
    parameter int unsigned id_width_p = 2
) (
    input  logic [num_req_p-1:0]  v_i,
    input  logic [id_width_p-1:0] last_i,
    output logic [num_req_p-1:0]  grant_o,
    output logic [id_width_p-1:0] id_o
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 1; off <= num_req_p; off++) begin
            idx = (32'(last_i) + off) % num_req_p;
            if (!found && v_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = id_width_p'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_edge_arbiter.sv
// Round-robin, credit-gated sharing of one mesh edge injection port with a
// single-entry output buffer and a drain/idle handshake for quiescing.
module bsg_manycore_edge_arbiter
    import bsg_vscale_pkg::*;
#(
    parameter int unsigned num_req_p        = 4,
    parameter int unsigned packet_width_p   = 32,
    parameter int unsigned max_credits_p    = 8,
    parameter bit          overflow_check_p = 1'b1,
    localparam int unsigned credit_width_lp = safe_clog2(max_credits_p + 1),
    localparam int unsigned id_width_lp     = safe_clog2(num_req_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [num_req_p-1:0][packet_width_p-1:0]  req_data_i,
    input  logic [num_req_p-1:0]                      req_v_i,
    output logic [num_req_p-1:0]                      req_ready_o,
    output logic [packet_width_p-1:0]                 link_data_o,
    output logic                                      link_v_o,
    input  logic                                      link_ready_i,
    input  logic                                      credit_return_i,
    input  logic                                      drain_i,
    output logic [credit_width_lp-1:0]                out_credits_o,
    output logic                                      idle_o,
    output logic [id_width_lp-1:0]                    grant_id_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
    localparam logic [id_width_lp-1:0]     last_init_lp   = id_width_lp'(num_req_p - 1);

    bsg_edge_arb_state_e state_q, state_n;

    logic [packet_width_p-1:0]  data_q;
    logic                       v_q;
    logic [credit_width_lp-1:0] credits_q, credits_n;
    logic [id_width_lp-1:0]     last_q, gid_q;

    logic [num_req_p-1:0]   pick_grant;
    logic [id_width_lp-1:0] pick_id;
    logic                   retire, grant_en, accept;

    bsg_round_robin_pick #(
        .num_req_p  (num_req_p),
        .id_width_p (id_width_lp)
    ) pick (
        .v_i     (req_v_i),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .id_o    (pick_id)
    );

    assign retire   = v_q & link_ready_i;
    assign grant_en = !reset_i && (!v_q || link_ready_i) && (credits_q != '0) && (state_q == RUN);
    assign req_ready_o = grant_en ? pick_grant : '0;
    assign accept   = |(req_v_i & req_ready_o);

    always_comb begin
        credits_n = credits_q;
        if (accept && !credit_return_i)
            credits_n = credits_q - 1'b1;
        else if (!accept && credit_return_i && credits_q != max_credits_lp)
            credits_n = credits_q + 1'b1;
    end

    // IDLE is entered on the same edge that brings the last credit home, so
    // the completion test looks at next-cycle credit and buffer values.
    always_comb begin
        state_n = state_q;
        case (state_q)
            RUN:     if (drain_i) state_n = DRAIN;
            DRAIN:   if (!drain_i) state_n = RUN;
                     else if ((!v_q || retire) && credits_n == max_credits_lp) state_n = IDLE;
            IDLE:    if (!drain_i) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= RUN;
            v_q       <= 1'b0;
            data_q    <= '0;
            credits_q <= max_credits_lp;
            last_q    <= last_init_lp;
            gid_q     <= '0;
        end else begin
            state_q   <= state_n;
            credits_q <= credits_n;
            if (accept) begin
                v_q    <= 1'b1;
                data_q <= req_data_i[pick_id];
                last_q <= pick_id;
                gid_q  <= pick_id;
            end else if (retire) begin
                v_q <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (overflow_check_p && !reset_i && credit_return_i && !accept && credits_q == max_credits_lp)
            $error("bsg_manycore_edge_arbiter: credit return with all credits home");
    end
`endif

    assign link_v_o      = v_q;
    assign link_data_o   = data_q;
    assign out_credits_o = credits_q;
    assign grant_id_o    = gid_q;
    assign idle_o        = (state_q == IDLE);

endmodule

// File: tb/tb_bsg_manycore_edge_arbiter.sv
// Directed vector bench for bsg_manycore_edge_arbiter (4 requesters, 8 credits).
module tb_bsg_manycore_edge_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0][31:0]  req_data;
    logic [3:0]        req_v;
    logic [3:0]        req_ready;
    logic [31:0]       link_data;
    logic              link_v;
    logic              link_ready;
    logic              credit_return;
    logic              drain;
    logic [3:0]        out_credits;
    logic              idle;
    logic [1:0]        grant_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_manycore_edge_arbiter #(
        .num_req_p        (4),
        .packet_width_p   (32),
        .max_credits_p    (8),
        .overflow_check_p (1'b0)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .req_data_i      (req_data),
        .req_v_i         (req_v),
        .req_ready_o     (req_ready),
        .link_data_o     (link_data),
        .link_v_o        (link_v),
        .link_ready_i    (link_ready),
        .credit_return_i (credit_return),
        .drain_i         (drain),
        .out_credits_o   (out_credits),
        .idle_o          (idle),
        .grant_id_o      (grant_id)
    );

    typedef struct {
        logic [3:0] v;
        logic       lr;
        logic       ret;
        logic [3:0] rdy;
        logic       lv;
        logic [3:0] cred;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic lr, input logic ret,
                         input logic dr, input logic rst);
        @(negedge clk);
        req_v = v; link_ready = lr; credit_return = ret; drain = dr; reset = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] v, input logic lr, input logic ret,
                       input logic [3:0] rdy, input logic lv, input logic [3:0] cred,
                       input logic [1:0] gid, input int rep);
        for (int k = 0; k < rep; k++) tbl.push_back('{v, lr, ret, rdy, lv, cred, gid});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_data[i] = 32'hD0 + 32'(i);
        req_v = '0; link_ready = 1'b1; credit_return = 1'b0; drain = 1'b0; reset = 1'b1;

        // round-robin with a return each cycle keeps credits at 8
        add(4'hF, 1, 1, 4'h1, 1, 8, 0, 1);
        add(4'hF, 1, 1, 4'h2, 1, 8, 1, 1);
        add(4'hF, 1, 1, 4'h4, 1, 8, 2, 1);
        add(4'hF, 1, 1, 4'h8, 1, 8, 3, 1);
        add(4'hF, 1, 1, 4'h1, 1, 8, 0, 1);
        // ten requests with no returns: eight accepted
        add(4'hF, 1, 0, 4'h2, 1, 7, 1, 1);
        add(4'hF, 1, 0, 4'h4, 1, 6, 2, 1);
        add(4'hF, 1, 0, 4'h8, 1, 5, 3, 1);
        add(4'hF, 1, 0, 4'h1, 1, 4, 0, 1);
        add(4'hF, 1, 0, 4'h2, 1, 3, 1, 1);
        add(4'hF, 1, 0, 4'h4, 1, 2, 2, 1);
        add(4'hF, 1, 0, 4'h8, 1, 1, 3, 1);
        add(4'hF, 1, 0, 4'h1, 1, 0, 0, 1);
        add(4'hF, 1, 0, 4'h0, 0, 0, 0, 2);
        // one return enables exactly one more packet, next cycle
        add(4'hF, 1, 1, 4'h0, 0, 1, 0, 1);
        add(4'hF, 1, 0, 4'h2, 1, 0, 1, 1);
        add(4'hF, 1, 0, 4'h0, 0, 0, 1, 1);
        // refill to 3, then accept + return together
        add(4'h0, 1, 1, 4'h0, 0, 1, 1, 1);
        add(4'h0, 1, 1, 4'h0, 0, 2, 1, 1);
        add(4'h0, 1, 1, 4'h0, 0, 3, 1, 1);
        add(4'hF, 1, 1, 4'h4, 1, 3, 2, 1);
        add(4'h0, 1, 1, 4'h0, 0, 4, 2, 1);
        add(4'h0, 1, 1, 4'h0, 0, 5, 2, 1);
        add(4'h0, 1, 1, 4'h0, 0, 6, 2, 1);
        add(4'h0, 1, 1, 4'h0, 0, 7, 2, 1);
        add(4'h0, 1, 1, 4'h0, 0, 8, 2, 1);
        add(4'h0, 1, 1, 4'h0, 0, 8, 2, 1);  // saturation
        // backpressure for 5 cycles, then release
        add(4'hF, 1, 0, 4'h8, 1, 7, 3, 1);
        add(4'hF, 0, 0, 4'h0, 1, 7, 3, 5);
        add(4'hF, 1, 0, 4'h1, 1, 6, 0, 1);
        add(4'h0, 1, 1, 4'h0, 0, 7, 0, 1);
        add(4'h0, 1, 1, 4'h0, 0, 8, 0, 1);
        // three packets outstanding for the drain sequence
        add(4'hF, 1, 0, 4'h2, 1, 7, 1, 1);
        add(4'hF, 1, 0, 4'h4, 1, 6, 2, 1);
        add(4'hF, 1, 0, 4'h8, 1, 5, 3, 1);

        // reset state
        drive(4'hF, 1, 0, 0, 1);
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        chk("rst_link_v", 32'(link_v), 32'h0);
        chk("rst_link_data", link_data, 32'h0);
        chk("rst_credits", 32'(out_credits), 32'd8);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].lr, tbl[i].ret, 0, 0);
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("v%0d_link_v", i), 32'(link_v), 32'(tbl[i].lv));
            chk($sformatf("v%0d_credits", i), 32'(out_credits), 32'(tbl[i].cred));
            chk($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
            if (tbl[i].lv)
                chk($sformatf("v%0d_data", i), link_data, 32'hD0 + 32'(tbl[i].gid));
        end

        // drain: credits 5, buffer holds requester 3's packet
        drive(4'h0, 1, 0, 1, 0);
        tick();
        chk("drn_a_link_v", 32'(link_v), 32'd0);
        drive(4'hF, 1, 0, 1, 0);
        chk("drn_b_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drn_b_credits", 32'(out_credits), 32'd5);
        chk("drn_b_idle", 32'(idle), 32'd0);
        drive(4'hF, 1, 1, 1, 0);
        chk("drn_c_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drn_c_idle", 32'(idle), 32'd0);
        drive(4'hF, 1, 1, 1, 0);
        tick();
        chk("drn_d_credits", 32'(out_credits), 32'd7);
        chk("drn_d_idle", 32'(idle), 32'd0);
        drive(4'hF, 1, 1, 1, 0);
        chk("drn_e_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drn_e_credits", 32'(out_credits), 32'd8);
        chk("drn_e_idle", 32'(idle), 32'd1);
        drive(4'hF, 1, 0, 1, 0);
        chk("drn_f_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drn_f_idle", 32'(idle), 32'd1);
        drive(4'hF, 1, 0, 0, 0);
        chk("drn_g_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drn_g_idle", 32'(idle), 32'd0);
        chk("drn_g_link_v", 32'(link_v), 32'd0);
        drive(4'hF, 1, 0, 0, 0);
        chk("resume_ready", 32'(req_ready), 32'h1);
        tick();
        chk("resume_grant_id", 32'(grant_id), 32'd0);
        chk("resume_credits", 32'(out_credits), 32'd7);

        // reset with buffer full and credits 5
        drive(4'hF, 1, 0, 0, 0);
        tick();
        drive(4'hF, 1, 0, 0, 0);
        chk("pre_rst_ready", 32'(req_ready), 32'h4);
        tick();
        chk("pre_rst_credits", 32'(out_credits), 32'd5);
        chk("pre_rst_link_v", 32'(link_v), 32'd1);
        drive(4'hF, 0, 0, 0, 1);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("mid_rst_link_v", 32'(link_v), 32'd0);
        chk("mid_rst_credits", 32'(out_credits), 32'd8);
        chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
        drive(4'hF, 1, 0, 0, 0);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        chk("post_rst_data", link_data, 32'hD0);
        chk("post_rst_credits", 32'(out_credits), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
